// File: rtl/pc_gen_if.sv
// Fetch request channel between the next-PC stage and instruction memory.
// The master drives the address/valid; imem answers with ready.
interface pc_gen_if;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] pc_IF;

    modport master (output if_valid, output pc_IF, input if_ready);
    modport slave  (input if_valid, input pc_IF, output if_ready);
endinterface

// File: rtl/pc_gen.sv
// Next-PC stage: forms redirect targets, owns the IF program counter, issues fetches over a
// valid/ready channel and parks a redirect that arrives while imem is stalling the request.
module pc_gen #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        B_JUMP,
    input  logic        jalr,
    input  logic        jal,
    input  logic [31:0] offset,
    input  logic [31:0] imm_ID,
    input  logic [31:0] pc_ID,
    input  logic [31:0] pc_EX,
    pc_gen_if.master    fetch,
    output logic [31:0] pc_plus4,
    output logic        flush_IF,
    output logic        flush_ID,
    output logic        misalign
);

    typedef enum logic [1:0] {StBoot, StRun, StPend} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic        valid_q, valid_d;
    logic        misalign_q, misalign_d;
    logic [31:0] target;
    logic        redirect;
    logic        accept;

    // Older instruction (EX branch) takes priority over younger ID jumps.
    always_comb begin
        target = pc_ID + offset;
        if (B_JUMP) begin
            target = pc_EX + offset;
        end else if (jalr) begin
            target = (offset + imm_ID) & ~32'h1;
        end
    end

    assign redirect = (B_JUMP | jalr | jal) & (state_q != StBoot);
    assign accept   = valid_q & fetch.if_ready;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        valid_d    = valid_q;
        misalign_d = CHECK_ALIGN && redirect && (target[1:0] != 2'b00);
        unique case (state_q)
            StBoot: begin
                state_d = StRun;
                valid_d = 1'b1;
                pc_d    = RESET_PC;
            end
            StRun: begin
                if (redirect) begin
                    if (accept || !valid_q) begin
                        pc_d = target;
                    end else begin
                        pend_d  = target;
                        state_d = StPend;
                    end
                end else if (accept && !stall) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            StPend: begin
                if (accept) begin
                    pc_d    = redirect ? target : pend_q;
                    state_d = StRun;
                end else if (redirect) begin
                    pend_d = target;
                end
            end
            default: state_d = StBoot;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StBoot;
            pc_q       <= RESET_PC;
            pend_q     <= 32'h0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

    assign fetch.if_valid = valid_q;
    assign fetch.pc_IF    = pc_q;
    assign pc_plus4       = pc_q + 32'd4;
    assign flush_IF       = redirect;
    assign flush_ID       = B_JUMP;
    assign misalign       = misalign_q;

endmodule
